// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
//   Runs a 16-bit operation through an external 4-bit 74181-style ALU.
//   It does this one nibble per clock, over four cycles, and ripples the ALU
//   carry between nibbles through a register.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 operation request, accepted in IDLE or DONE
//   a, b [15:0]           operands, latched on an accepted start
//   s [3:0], m, cn        74181 select, mode and raw Cn, latched on start
//   alu_a, alu_b [3:0]    current operand nibbles driven to the ALU
//   alu_s [3:0], alu_m    latched select and mode driven to the ALU
//   alu_cn                ALU carry in: latched cn for nibble 0, else carry reg
//   alu_f [3:0]           ALU function output for the driven nibble
//   alu_cn4, alu_aeqb     ALU carry out and A=B output for the driven nibble
//   busy                  high while the operation is running
//   done                  one-cycle completion pulse
//   result [15:0]         assembled F, nibble k in bits [4k+3:4k]
//   cout                  raw alu_cn4 of the top nibble
//   aeqb                  AND of alu_aeqb over all four nibbles

module alu_nibble_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  s,
  input  logic        m,
  input  logic        cn,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_m,
  output logic        alu_cn,
  input  logic [3:0]  alu_f,
  input  logic        alu_cn4,
  input  logic        alu_aeqb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        aeqb
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  s_q, s_d;
  logic        m_q, m_d;
  logic        cn_q, cn_d;
  logic        carry_q, carry_d;
  logic        acc_q, acc_d;
  logic [15:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        aeqb_q, aeqb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      s_q      <= 4'h0;
      m_q      <= 1'b0;
      cn_q     <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= 1'b0;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      aeqb_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cn_q     <= cn_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      aeqb_q   <= aeqb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    cn_d     = cn_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    aeqb_d   = aeqb_q;

    case (state_q)
      IDLE, DONE: begin
        // Result, cout and aeqb are left alone here so the previous answer
        // stays visible until the new run overwrites it nibble by nibble.
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          cn_d    = cn;
          idx_d   = 2'd0;
          acc_d   = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = alu_f;
        carry_d = alu_cn4;
        acc_d   = acc_q & alu_aeqb;
        if (idx_q == 2'd3) begin
          // idx is parked at 0 so the ALU sees nibble 0 outside RUN.
          idx_d   = 2'd0;
          cout_d  = alu_cn4;
          aeqb_d  = acc_q & alu_aeqb;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // idx is always 0 outside RUN, so these show nibble 0 and the latched cn there.
  assign alu_a  = a_q[{idx_q, 2'b00} +: 4];
  assign alu_b  = b_q[{idx_q, 2'b00} +: 4];
  assign alu_cn = (idx_q == 2'd0) ? cn_q : carry_q;
  assign alu_s  = s_q;
  assign alu_m  = m_q;

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign aeqb   = aeqb_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer
//   Directed bench for alu_nibble_sequencer. A behavioural 74181 nibble model
//   (active-high data, active-low carry) stands in for the external ALU.

module tb_alu_nibble_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        m, cn;
  logic [3:0]  alu_a, alu_b, alu_s;
  logic        alu_m, alu_cn;
  logic [3:0]  alu_f;
  logic        alu_cn4, alu_aeqb;
  logic        busy, done;
  logic [15:0] result;
  logic        cout, aeqb;

  int errors = 0;
  int checks = 0;

  alu_nibble_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .s(s), .m(m), .cn(cn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb),
    .busy(busy), .done(done), .result(result), .cout(cout), .aeqb(aeqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 74181 nibble: arithmetic F = P plus G plus carry, logic F = ~(P ^ G).
  // The carry in is ~Cn, and Cn+4 is the inverted carry out of the sum.
  function automatic logic [5:0] alu181(input logic [3:0] av, bv, sv,
                                        input logic mv, cnv);
    logic [3:0] p, g, f;
    logic [4:0] sum;
    p   = av | (bv & {4{sv[0]}}) | (~bv & {4{sv[1]}});
    g   = av & ((bv & {4{sv[3]}}) | (~bv & {4{sv[2]}}));
    sum = {1'b0, p} + {1'b0, g} + {4'b0000, ~cnv};
    f   = mv ? ~(p ^ g) : sum[3:0];
    return {(f == 4'hF), ~sum[4], f};
  endfunction

  always_comb begin
    {alu_aeqb, alu_cn4, alu_f} = alu181(alu_a, alu_b, alu_s, alu_m, alu_cn);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation with start high for a single edge; returns at the
  // falling edge just after the accepting edge.
  task automatic applyStimulus(input logic [15:0] av, bv, input logic [3:0] sv,
                               input logic mv, cnv);
    @(negedge clk);
    a = av; b = bv; s = sv; m = mv; cn = cnv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic runOp(input string tag, input logic [15:0] av, bv,
                       input logic [3:0] sv, input logic mv, cnv,
                       input logic [15:0] expResult, input logic expAeqb,
                       input logic chkCout, input logic expCout);
    int cyc;
    applyStimulus(av, bv, sv, mv, cnv);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    waitDone(cyc);
    checkOutput({tag, " latency"}, 32'(cyc), 32'd4);
    checkOutput({tag, " result"}, 32'(result), 32'(expResult));
    checkOutput({tag, " aeqb"}, 32'(aeqb), 32'(expAeqb));
    if (chkCout) checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, " alu_a nib0"}, 32'(alu_a), 32'(av[3:0]));
    checkOutput({tag, " alu_cn idle"}, 32'(alu_cn), 32'(cnv));
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " result hold"}, 32'(result), 32'(expResult));
  endtask

  initial begin
    int cyc, doneCnt, busyCnt, firstDone, secondDone;
    logic [15:0] firstRes, secondRes;

    rst_n = 1'b0; start = 1'b0;
    a = 16'h0; b = 16'h0; s = 4'h0; m = 1'b0; cn = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset aeqb", 32'(aeqb), 32'd0);
    checkOutput("reset alu_cn", 32'(alu_cn), 32'd0);
    checkOutput("reset alu_s", 32'(alu_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("add",    16'h1234, 16'h0F0F, 4'b1001, 1'b0, 1'b1, 16'h2143, 1'b0, 1'b1, 1'b1);
    runOp("ripple", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    runOp("sub eq", 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    runOp("sub ne", 16'h1234, 16'h1235, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1);
    runOp("xor",    16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 16'hAA55, 1'b0, 1'b0, 1'b0);
    checkOutput("xor alu_m", 32'(alu_m), 32'd1);

    // start pulsed in RUN cycle 2 with different operands must be ignored
    applyStimulus(16'h1234, 16'h0F0F, 4'b1001, 1'b0, 1'b1);
    doneCnt = 0; firstDone = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 2) begin
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; s = 4'h0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (firstDone == 0) begin
          firstDone = i;
          firstRes  = result;
        end
      end
    end
    checkOutput("ignore done count", 32'(doneCnt), 32'd1);
    checkOutput("ignore done time", 32'(firstDone), 32'd4);
    checkOutput("ignore result", 32'(firstRes), 32'h2143);
    checkOutput("ignore alu_s", 32'(alu_s), 32'b1001);

    // start held high through DONE gives back-to-back operations
    @(negedge clk);
    a = 16'h1234; b = 16'h0F0F; s = 4'b1001; m = 1'b0; cn = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 16'hA5A5; b = 16'h0FF0; s = 4'b0110; m = 1'b1;
    doneCnt = 0; firstDone = 0; secondDone = 0;
    firstRes = 16'h0; secondRes = 16'h0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 5) start = 1'b0;
      if (done) begin
        doneCnt++;
        if (firstDone == 0) begin
          firstDone = i; firstRes = result;
        end else if (secondDone == 0) begin
          secondDone = i; secondRes = result;
        end
      end
    end
    checkOutput("b2b done count", 32'(doneCnt), 32'd2);
    checkOutput("b2b first time", 32'(firstDone), 32'd4);
    checkOutput("b2b second time", 32'(secondDone), 32'd9);
    checkOutput("b2b first result", 32'(firstRes), 32'h2143);
    checkOutput("b2b second result", 32'(secondRes), 32'hAA55);

    // reset in RUN cycle 3 aborts with no done pulse
    applyStimulus(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort result", 32'(result), 32'd0);
    checkOutput("abort cout", 32'(cout), 32'd0);
    checkOutput("abort aeqb", 32'(aeqb), 32'd0);
    checkOutput("abort alu_a", 32'(alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0; busyCnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      if (busy) busyCnt++;
    end
    checkOutput("abort no done", 32'(doneCnt), 32'd0);
    checkOutput("abort stays idle", 32'(busyCnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled at rising clk, accepted only in IDLE or DONE.
REQ-005 a, b  input  16 each  operands, latched on accepted start.
REQ-006 s  input  4  74181 function select, latched on accepted start.
REQ-007 m  input  1  74181 mode (1 logic, 0 arithmetic), latched on accepted start.
REQ-008 cn  input  1  raw 74181 Cn for nibble 0, latched on accepted start; no polarity translation.
REQ-009 alu_a, alu_b  output  4 each  current nibble of the latched operands, to the external 4-bit ALU.
REQ-010 alu_s, alu_m  output  4, 1  latched s and m, to the ALU.
REQ-011 alu_cn  output  1  ALU carry input: latched cn for nibble 0, captured alu_cn4 of the previous nibble otherwise.
REQ-012 alu_f, alu_cn4, alu_aeqb  input  4, 1, 1  combinational ALU results for the driven nibble.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  single-cycle completion pulse.
REQ-015 result  output  16  assembled F, nibble k in bits [4k+3:4k].
REQ-016 cout  output  1  raw alu_cn4 of nibble 3.
REQ-017 aeqb  output  1  AND of alu_aeqb over all four nibbles.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-019 IDLE: start=1 latches a, b, s, m, cn, clears idx to 0, clears aeqb accumulator to 1, and moves to RUN; start=0 stays in IDLE.
REQ-020 RUN: each rising edge captures alu_f into result nibble idx, captures alu_cn4 into the carry register, ANDs alu_aeqb into the accumulator, and increments idx.
REQ-021 RUN: the edge that captures idx=3 moves to DONE and updates cout and aeqb.
REQ-022 idx SHALL be a 2-bit counter that is never observed wrapping; RUN SHALL always last exactly 4 cycles.
REQ-023 DONE: done=1 for exactly this one cycle; start=1 behaves as in IDLE (back-to-back), otherwise the FSM moves to IDLE.
REQ-024 Latency: start accepted at edge t gives done high during the cycle after edge t+4; issue interval SHALL be 5 cycles.
REQ-025 start while in RUN SHALL be ignored, with no effect on the latched operands or outputs.
REQ-026 alu_a, alu_b, and alu_cn SHALL be combinational from the latched registers and idx; outside RUN they SHALL show nibble 0 and latched cn.
REQ-027 result, cout, and aeqb SHALL hold from DONE until the next RUN starts writing; partial nibbles are visible during RUN.
REQ-028 The carry chain SHALL be used identically when m=1; the block SHALL NOT interpret carry polarity.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with busy=0, done=0, result=0, cout=0, aeqb=0, idx=0, all latched operands 0, and the carry register 0.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse; operation resumes only on a new start after rst_n deasserts.

Verification
REQ-031 Add: a=0x1234, b=0x0F0F, s=1001, m=0, cn=1 -> after 5 cycles done=1, result=0x2143, cout=1.
REQ-032 Add with carry ripple: a=0xFFFF, b=0x0001, s=1001, m=0, cn=1 -> result=0x0000, cout=0.
REQ-033 Subtract/compare: a=0x1234, b=0x1234, s=0110, m=0, cn=1 -> result=0xFFFF, aeqb=1; repeat with b=0x1235 -> aeqb=0.
REQ-034 Logic XOR: a=0xA5A5, b=0x0FF0, s=0110, m=1, cn=1 -> result=0xAA55.
REQ-035 start pulsed during RUN cycle 2 -> ignored, and a single done fires at the original time; start held high through DONE -> back-to-back operation with done every 5 cycles.
REQ-036 rst_n pulsed low in RUN cycle 3 -> outputs are zero immediately, no done pulse occurs, and the FSM stays in IDLE.
